layer2_pingpong_ctrl: RTL and testbench
=======================================

Name: layer2_pingpong_ctrl

Overview:
- Controller that shares one 512-entry, 18-bit layer-2 feature-map RAM between two requesters: the layer-2 producer (writer) and the layer-3 consumer (reader).
- The RAM is split into two 256-word banks (bank 0 = addr 0..255, bank 1 = addr 256..511). Banks are used ping-pong.
- The block tracks bank ownership, generates RAM write and read addresses, and throttles both sides so a bank is never overwritten before it is drained.
- It sits between the conv/pool output of layer 2 and the layer-3 input fetch.

Parameters:
- DATA_W, 18, feature word width (signed, passed through unmodified).
- BANK_DEPTH, 256, words per bank; must be a power of two.
- ADDR_W, 9, RAM address width = log2(2*BANK_DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- soft_clr  in  1  synchronous per-image restart; same effect as reset.
- in_valid  in  1  producer has a word.
- in_data  in  DATA_W  producer word (signed).
- in_ready  out  1  controller accepts the word this cycle.
- ram_we  out  1  RAM write strobe.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- fill_done  out  1  one-cycle pulse when a bank becomes FULL.
- rd_avail  out  1  a FULL or DRAINING bank is readable.
- rd_req  in  1  consumer requests the next word.
- ram_re  out  1  RAM read strobe.
- ram_raddr  out  ADDR_W  RAM read address.
- rd_last  out  1  asserted with the ram_re of the last word of a bank.
- rd_bank  out  1  bank currently owned by the reader.

Behaviour:
- Per-bank state, 2 bits each: EMPTY -> FULL -> DRAINING -> EMPTY. Write pointer wr_bank and wr_cnt (log2 BANK_DEPTH bits); read pointer rd_bank and rd_cnt.
- Reset (rst_n low, async) or soft_clr (sync): both banks EMPTY; wr_bank = rd_bank = 0; both counters 0; all outputs 0. Bank contents are logically discarded. soft_clr takes priority over any accept or read in the same cycle.
- in_ready = (state[wr_bank] == EMPTY). It is combinational from registered state only, never from in_valid.
- Accept = in_valid & in_ready. Next cycle: ram_we = 1, ram_waddr = {wr_bank, wr_cnt}, ram_wdata = in_data. Write latency is 1 cycle.
- ram_we = 0 in any cycle with no accept in the previous cycle.
- Accept with wr_cnt == BANK_DEPTH-1:
  - state[wr_bank] becomes FULL; wr_cnt wraps to 0; wr_bank toggles.
  - fill_done pulses 1 cycle, aligned with the final ram_we.
- If the new wr_bank is not EMPTY, in_ready stays 0 (producer stalls) until the reader frees it.
- rd_avail = (state[rd_bank] == FULL or DRAINING).
- rd_req & rd_avail: next cycle ram_re = 1, ram_raddr = {rd_bank, rd_cnt}; rd_cnt increments. FULL becomes DRAINING on the first read.
- rd_req while !rd_avail is ignored: no ram_re, no counter change.
- Read with rd_cnt == BANK_DEPTH-1: rd_last = 1 with that ram_re; state[rd_bank] becomes EMPTY; rd_cnt wraps; rd_bank toggles.
- Simultaneous events:
  - Write-complete on one bank and read-complete on the other in the same cycle: both transitions apply.
  - Writer and reader can never own the same bank, since the writer uses EMPTY banks and the reader uses FULL/DRAINING banks.
  - A bank freed by the reader is visible to in_ready one cycle later (one bubble; required).
- The same bank cannot be FULL and targeted by the writer. Overflow is structurally impossible.

Decomposition:
- Shared package holds:
  - constants DATA_W = 18, BANK_DEPTH = 256, ADDR_W = 9;
  - bank-state encoding: EMPTY = 2'b00, FULL = 2'b01, DRAINING = 2'b10.
- One natural sub-module: layer2_bank_state. It holds one bank's 2-bit state register with inputs set_full, start_drain, set_empty, clr. It is instantiated twice. Pointer and counter logic stay in the top module.

Test Plan:
- Reset, then 256 accepts at in_valid = 1 with in_data = index → ram_waddr 0..255; fill_done pulses once at the 256th ram_we; in_ready stays 1; the next write goes to 256.
- Fill 512 words without reading → in_ready drops after the 512th accept; in_valid held for 10 more cycles produces no ram_we.
- Then rd_req for 256 cycles → ram_raddr 0..255; rd_last on addr 255; in_ready rises one cycle after the last read; the next write goes to address 0.
- Concurrent streaming at full rate on both sides for 2048 words → no stall after initial fill; ram_raddr never equals an address written in the same bank since its fill_done.
- rd_req asserted from reset with no data → no ram_re until the first fill_done; the first ram_re goes to address 0.
- soft_clr mid-fill at wr_cnt = 100, and rst_n pulsed low asynchronously mid-drain → all states EMPTY, pointers 0, outputs 0; the next accept writes address 0.

Source files
------------

// File: rtl/layer2_pingpong_ctrl_pkg.sv
// Shared definitions for the layer-2 ping-pong feature-map RAM controller.
// Holds the RAM geometry constants, the per-bank ownership state encoding
// and a helper that forms a RAM address from a bank index and word offset.
package layer2_pingpong_ctrl_pkg;

    localparam int DATA_W     = 18;
    localparam int BANK_DEPTH = 256;
    localparam int ADDR_W     = 9;
    localparam int CNT_W      = $clog2(BANK_DEPTH);

    typedef enum logic [1:0] {
        BS_EMPTY    = 2'b00,
        BS_FULL     = 2'b01,
        BS_DRAINING = 2'b10
    } bank_state_e;

    // The bank index is the address MSB, so a bank is a contiguous half of the RAM.
    function automatic logic [ADDR_W-1:0] bank_addr(input logic bank, input logic [CNT_W-1:0] cnt);
        return {bank, cnt};
    endfunction

endpackage

// File: rtl/layer2_bank_state.sv
// Ownership state of one RAM bank: EMPTY -> FULL -> DRAINING -> EMPTY.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_clr              synchronous restart, forces EMPTY
//   i_set_full         writer stored the last word of this bank
//   i_start_drain      reader fetched a word from this bank
//   i_set_empty        reader fetched the last word of this bank
//   o_state            registered bank state
module layer2_bank_state
    import layer2_pingpong_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_set_full,
    input  logic        i_start_drain,
    input  logic        i_set_empty,
    output bank_state_e o_state
);

    bank_state_e r_state;
    bank_state_e w_next;

    // Next-state decode; each event is honoured only in the state where it is legal.
    always_comb begin
        w_next = r_state;
        case (r_state)
            BS_EMPTY: begin
                if (i_set_full) w_next = BS_FULL;
                else            w_next = BS_EMPTY;
            end
            BS_FULL: begin
                // set_empty first covers a read of the only word of a bank
                if (i_set_empty)        w_next = BS_EMPTY;
                else if (i_start_drain) w_next = BS_DRAINING;
                else                    w_next = BS_FULL;
            end
            BS_DRAINING: begin
                if (i_set_empty) w_next = BS_EMPTY;
                else             w_next = BS_DRAINING;
            end
            default: w_next = BS_EMPTY;
        endcase
    end

    // State register; clear wins over every event in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_state <= BS_EMPTY;
        else if (i_clr) r_state <= BS_EMPTY;
        else            r_state <= w_next;
    end

    assign o_state = r_state;

endmodule

// File: rtl/layer2_pingpong_ctrl.sv
// Ping-pong controller sharing one 512 x 18 feature-map RAM between the
// layer-2 producer (writer) and the layer-3 consumer (reader).
// Ports:
//   i_clk, i_rst_n, i_soft_clr          clock, async reset, per-image restart
//   i_in_valid, i_in_data, o_in_ready   producer handshake
//   o_ram_we, o_ram_waddr, o_ram_wdata  RAM write port (1-cycle latency)
//   o_fill_done                         pulse with the last write of a bank
//   o_rd_avail, i_rd_req                consumer handshake
//   o_ram_re, o_ram_raddr, o_rd_last    RAM read port (1-cycle latency)
//   o_rd_bank                           bank currently owned by the reader
module layer2_pingpong_ctrl
    import layer2_pingpong_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_soft_clr,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_waddr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_fill_done,
    output logic              o_rd_avail,
    input  logic              i_rd_req,
    output logic              o_ram_re,
    output logic [ADDR_W-1:0] o_ram_raddr,
    output logic              o_rd_last,
    output logic              o_rd_bank
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BANK_DEPTH - 1);

    logic              r_wr_bank;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic              r_rd_bank;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_waddr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_fill_done;
    logic              r_ram_re;
    logic [ADDR_W-1:0] r_ram_raddr;
    logic              r_rd_last;

    bank_state_e w_bank_state [2];
    logic [1:0]  w_set_full;
    logic [1:0]  w_start_drain;
    logic [1:0]  w_set_empty;
    bank_state_e w_wr_state;
    bank_state_e w_rd_state;
    logic        w_in_ready;
    logic        w_rd_avail;
    logic        w_accept;
    logic        w_read;
    logic        w_wr_last;
    logic        w_rd_last;

    // Handshakes depend on registered bank state only, never on in_valid/rd_req.
    assign w_wr_state = w_bank_state[r_wr_bank];
    assign w_rd_state = w_bank_state[r_rd_bank];
    assign w_in_ready = (w_wr_state == BS_EMPTY);
    assign w_rd_avail = (w_rd_state == BS_FULL) || (w_rd_state == BS_DRAINING);
    assign w_accept   = i_in_valid & w_in_ready;
    assign w_read     = i_rd_req & w_rd_avail;
    assign w_wr_last  = (r_wr_cnt == LAST_CNT);
    assign w_rd_last  = (r_rd_cnt == LAST_CNT);

    for (genvar g = 0; g < 2; g++) begin : g_bank
        assign w_set_full[g]    = w_accept & w_wr_last & (r_wr_bank == 1'(g));
        assign w_start_drain[g] = w_read & (r_rd_bank == 1'(g));
        assign w_set_empty[g]   = w_read & w_rd_last & (r_rd_bank == 1'(g));

        layer2_bank_state u_bank_state (
            .i_clk         (i_clk),
            .i_rst_n       (i_rst_n),
            .i_clr         (i_soft_clr),
            .i_set_full    (w_set_full[g]),
            .i_start_drain (w_start_drain[g]),
            .i_set_empty   (w_set_empty[g]),
            .o_state       (w_bank_state[g])
        );
    end

    // Write pointer and registered RAM write port; counter wraps naturally at BANK_DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_ram_we    <= 1'b0;
            r_ram_waddr <= '0;
            r_ram_wdata <= '0;
            r_fill_done <= 1'b0;
        end else if (i_soft_clr) begin
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_ram_we    <= 1'b0;
            r_ram_waddr <= '0;
            r_ram_wdata <= '0;
            r_fill_done <= 1'b0;
        end else begin
            r_ram_we    <= w_accept;
            r_fill_done <= w_accept & w_wr_last;
            if (w_accept) begin
                r_ram_waddr <= bank_addr(r_wr_bank, r_wr_cnt);
                r_ram_wdata <= i_in_data;
                r_wr_cnt    <= r_wr_cnt + CNT_W'(1);
                if (w_wr_last) r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Read pointer and registered RAM read port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_ram_re    <= 1'b0;
            r_ram_raddr <= '0;
            r_rd_last   <= 1'b0;
        end else if (i_soft_clr) begin
            r_rd_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_ram_re    <= 1'b0;
            r_ram_raddr <= '0;
            r_rd_last   <= 1'b0;
        end else begin
            r_ram_re  <= w_read;
            r_rd_last <= w_read & w_rd_last;
            if (w_read) begin
                r_ram_raddr <= bank_addr(r_rd_bank, r_rd_cnt);
                r_rd_cnt    <= r_rd_cnt + CNT_W'(1);
                if (w_rd_last) r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_rd_avail  = w_rd_avail;
    assign o_ram_we    = r_ram_we;
    assign o_ram_waddr = r_ram_waddr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_fill_done = r_fill_done;
    assign o_ram_re    = r_ram_re;
    assign o_ram_raddr = r_ram_raddr;
    assign o_rd_last   = r_rd_last;
    assign o_rd_bank   = r_rd_bank;

endmodule

// File: tb/tb_layer2_pingpong_ctrl.sv
// Scoreboard bench for layer2_pingpong_ctrl: directed stimulus pushes the
// expected RAM writes/reads into queues; a negedge monitor pops and compares
// whenever the DUT strobes ram_we or ram_re.
module tb_layer2_pingpong_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        soft_clr;
    logic        in_valid;
    logic [17:0] in_data;
    logic        in_ready;
    logic        ram_we;
    logic [8:0]  ram_waddr;
    logic [17:0] ram_wdata;
    logic        fill_done;
    logic        rd_avail;
    logic        rd_req;
    logic        ram_re;
    logic [8:0]  ram_raddr;
    logic        rd_last;
    logic        rd_bank;

    int checks = 0;
    int errors = 0;

    logic [27:0] wq [$];   // {fill_done, waddr, wdata}
    logic [9:0]  rq [$];   // {rd_last, raddr}

    always #5 clk = ~clk;

    layer2_pingpong_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_soft_clr  (soft_clr),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_ram_we    (ram_we),
        .o_ram_waddr (ram_waddr),
        .o_ram_wdata (ram_wdata),
        .o_fill_done (fill_done),
        .o_rd_avail  (rd_avail),
        .i_rd_req    (rd_req),
        .o_ram_re    (ram_re),
        .o_ram_raddr (ram_raddr),
        .o_rd_last   (rd_last),
        .o_rd_bank   (rd_bank)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the head of its queue; idle cycles must not pulse flags.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual_addr=%0d expected=none t=%0t", ram_waddr, $time);
                end else begin
                    logic [27:0] e;
                    e = wq.pop_front();
                    chk("waddr", 32'(ram_waddr), 32'(e[26:18]));
                    chk("wdata", 32'(ram_wdata), 32'(e[17:0]));
                    chk("fill_done", 32'(fill_done), 32'(e[27]));
                end
            end else begin
                chk("fill_done_idle", 32'(fill_done), 32'd0);
            end
            if (ram_re) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read actual_addr=%0d expected=none t=%0t", ram_raddr, $time);
                end else begin
                    logic [9:0] r;
                    r = rq.pop_front();
                    chk("raddr", 32'(ram_raddr), 32'(r[8:0]));
                    chk("rd_last", 32'(rd_last), 32'(r[9]));
                end
            end else begin
                chk("rd_last_idle", 32'(rd_last), 32'd0);
            end
        end
    end

    // One cycle of stimulus starting at posedge+1; exp_rdy < 0 skips the in_ready check.
    task automatic step(input logic v, input logic [17:0] d, input logic rr, input int exp_rdy);
        in_valid = v;
        in_data  = d;
        rd_req   = rr;
        @(negedge clk);
        if (exp_rdy >= 0) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_ram_we"},   32'(ram_we),    32'd0);
        chk({tag, "_ram_re"},   32'(ram_re),    32'd0);
        chk({tag, "_fill"},     32'(fill_done), 32'd0);
        chk({tag, "_rd_last"},  32'(rd_last),   32'd0);
        chk({tag, "_rd_avail"}, 32'(rd_avail),  32'd0);
        chk({tag, "_rd_bank"},  32'(rd_bank),   32'd0);
        chk({tag, "_waddr"},    32'(ram_waddr), 32'd0);
        chk({tag, "_raddr"},    32'(ram_raddr), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        soft_clr = 1'b0;
        in_valid = 1'b0;
        in_data  = 18'd0;
        rd_req   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cleared("reset");
        @(posedge clk);
        #1;

        // Fill bank 0 then bank 1 without reading.
        for (int i = 0; i < 256; i++) begin
            wq.push_back({1'(i == 255), 9'(i), 18'(i)});
            step(1'b1, 18'(i), 1'b0, 1);
        end
        for (int i = 0; i < 256; i++) begin
            wq.push_back({1'(i == 255), 9'(256 + i), 18'(1000 + i)});
            step(1'b1, 18'(1000 + i), 1'b0, 1);
        end
        // Both banks full: producer stalls, no writes.
        for (int i = 0; i < 10; i++) step(1'b1, 18'd5000, 1'b0, 0);
        chk("rd_avail_full", 32'(rd_avail), 32'd1);
        chk("rd_bank_first", 32'(rd_bank), 32'd0);

        // Drain bank 0; producer keeps in_valid high and restarts at address 0.
        for (int k = 0; k < 256; k++) begin
            rq.push_back({1'(k == 255), 9'(k)});
            step(1'b1, 18'd2000, 1'b1, 0);
        end
        wq.push_back({1'b0, 9'd0, 18'd2000});
        step(1'b1, 18'd2000, 1'b0, 1);
        chk("rd_bank_after_drain", 32'(rd_bank), 32'd1);

        // Continue bank 0 to wr_cnt = 100, then soft clear with accept and read pending.
        for (int i = 1; i < 100; i++) begin
            wq.push_back({1'b0, 9'(i), 18'(3000 + i)});
            step(1'b1, 18'(3000 + i), 1'b0, 1);
        end
        soft_clr = 1'b1;
        step(1'b1, 18'd9, 1'b1, 1);
        soft_clr = 1'b0;
        in_valid = 1'b0;
        rd_req   = 1'b0;
        @(negedge clk);
        chk_cleared("soft_clr");
        @(posedge clk);
        #1;

        // Refill bank 0 from address 0, then partially drain it.
        for (int i = 0; i < 256; i++) begin
            wq.push_back({1'(i == 255), 9'(i), 18'(4000 + i)});
            step(1'b1, 18'(4000 + i), 1'b0, 1);
        end
        for (int i = 0; i < 50; i++) begin
            rq.push_back({1'b0, 9'(i)});
            step(1'b0, 18'd0, 1'b1, 1);
        end
        step(1'b0, 18'd0, 1'b0, 1);

        // Asynchronous reset mid-drain, mid-cycle; rd_req held from reset onward.
        #1;
        rst_n  = 1'b0;
        rd_req = 1'b1;
        #1;
        chk_cleared("async_rst");
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-rate streaming on both sides: writer never stalls, reads trail by one bank.
        for (int t = 0; t < 2304; t++) begin
            if (t < 2048) wq.push_back({1'((t % 256) == 255), 9'(t % 512), 18'(t * 3 + 7)});
            if (t >= 256) rq.push_back({1'(((t - 256) % 256) == 255), 9'((t - 256) % 512)});
            step(1'(t < 2048), 18'(t * 3 + 7), 1'b1, (t < 2048) ? 1 : -1);
        end
        step(1'b0, 18'd0, 1'b0, -1);
        step(1'b0, 18'd0, 1'b0, -1);
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        chk("read_queue_drained", 32'(rq.size()), 32'd0);
        chk("rd_avail_end", 32'(rd_avail), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
